dsp_simd_add: RTL and testbench
===============================

Name: dsp_simd_add

Overview:
- Lane-parallel (SIMD) two-operand adder modeled on the UltraScale DSP48E2 ALU, which operates as one 48-bit, two 24-bit or four 12-bit adders.
- A single parameterized block covers the scalar (1 lane), dual (2 lanes) and triple (3 lanes) add primitives used by the code generator.
- Sits in the primitive library; it is instantiated by generated netlists wherever add instructions are mapped to DSP slices.

Parameters:
- LANES, default 1: number of independent adds; legal values 1, 2, 3.
- WIDTH, default 8: bits per lane; legal ranges 1..48 for LANES=1, 1..24 for LANES=2, 1..12 for LANES=3.

Ports:
- clock  input  1  system clock; used only when the optional feature is enabled.
- reset  input  1  asynchronous, active-low reset; used only when the optional feature is enabled.
- a  input  LANES*WIDTH  packed operand A; lane i = a[i*WIDTH +: WIDTH].
- b  input  LANES*WIDTH  packed operand B, same packing as a.
- y  output  LANES*WIDTH  packed sums, same packing as a.
- co  output  LANES  co[i] is the carry out of lane i.

Behaviour:
- Per lane: y_i = (a_i + b_i) mod 2^WIDTH and co[i] = bit WIDTH of the zero-extended sum.
- Two's complement: signed and unsigned interpretations give identical y bits.
- Internal 48-bit ALU word is split into SEG slots:
  - SEG=1 when LANES=1; SEG=2 when LANES=2; SEG=4 when LANES=3.
  - Slot width S = 48/SEG; lane i occupies slot i at offset i*S.
  - Each operand lane is zero-extended to S bits.
  - Slot 3 is tied to zero when LANES=3; its result is discarded.
- Carries never propagate across slot boundaries; a carry out of lane i must not disturb lane i+1.
- co[i] is taken from slot bit i*S+WIDTH when WIDTH<S, otherwise from the slot carry out.
- Default build (feature off):
  - Purely combinational, zero-cycle latency.
  - Outputs follow inputs within the same cycle.
  - clock and reset are unused (no state), so no reset value applies.
- Illegal LANES/WIDTH combinations cause an elaboration-time fatal error (generate-time check). No truncation or silent fallback.
- Boundary conditions:
  - All-ones + 1 wraps to 0 with co=1.
  - 0 + 0 gives 0 with co=0.
  - Maximum lane values in every lane simultaneously must stay lane-isolated.
  - X/Z inputs propagate; no special handling.

Optional Feature:
- Macro DSP_SIMD_ADD_PREG_EN.
- When defined:
  - y and co are registered (DSP P-register equivalent), giving 1-cycle latency.
  - Registers update on the rising edge of clock.
  - reset low asynchronously clears y and co to all zeros; they stay zero while reset is low.
  - The first valid result appears on the first rising edge after reset is released.
  - Assertion of reset mid-stream discards in-flight results immediately.
- When undefined: combinational behaviour as above; no flops are inferred.

Test Plan:
- LANES=1, WIDTH=8: a=0xFF, b=0x10 -> y=0x0F, co=1.
- LANES=1, WIDTH=32: a=0x00000001, b=0xFFFF0001 -> y=0xFFFF0002, co=0.
- LANES=2, WIDTH=24:
  - Lane 0: a0=0xFFFFFF, b0=0x000010 -> y0=0x00000F, co0=1.
  - Lane 1: a1=23, b1=7 -> y1=30, co1=0.
  - Also checks that no carry leaks from lane 0 into lane 1.
- LANES=3, WIDTH=12:
  - Lane 0: (1, 0xFF0) -> 0xFF1, co=0.
  - Lane 1: (0xFE9, 0xFF9) -> 0xFE2, co=1.
  - Lane 2: (25, 7) -> 32, co=0.
- LANES=3, WIDTH=12, every lane 0xFFF + 0x001 -> each y_i=0x000, co=3'b111; then 0+0 -> y=0, co=0.
- With DSP_SIMD_ADD_PREG_EN, LANES=1, WIDTH=8:
  - Hold reset low -> y=0, co=0.
  - Release reset with a=0xFF, b=0x10 -> y=0x0F, co=1 after the first rising edge.
  - Drop reset mid-run -> y=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dsp_simd_add.sv
// dsp_simd_add: lane-parallel two-operand adder modelled on the DSP48E2 SIMD ALU.
// The 48-bit ALU word is split into 1, 2 or 4 slots; carries stop at slot edges.
// Optional macro DSP_SIMD_ADD_PREG_EN registers y/co (P-register, 1-cycle latency);
// without it the block is purely combinational and clock/reset are unused.
module dsp_simd_add #(
    parameter int unsigned LANES = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    output logic [LANES*WIDTH-1:0]   y,
    output logic [LANES-1:0]         co
);

    localparam int unsigned ALU_W = 48;
    localparam int unsigned SEG   = (LANES == 1) ? 1 : (LANES == 2) ? 2 : 4;
    localparam int unsigned S     = ALU_W / SEG;
    localparam int unsigned SUM_W = SEG * (S + 1);

    localparam bit LEGAL =
        ((LANES == 1) && (WIDTH >= 1) && (WIDTH <= 48)) ||
        ((LANES == 2) && (WIDTH >= 1) && (WIDTH <= 24)) ||
        ((LANES == 3) && (WIDTH >= 1) && (WIDTH <= 12));

    // Refuse to build an unsupported lane/width combination.
    if (!LEGAL) begin : g_bad_cfg
        $fatal(1, "dsp_simd_add: illegal LANES=%0d WIDTH=%0d", LANES, WIDTH);
    end

    logic [ALU_W-1:0]       alu_a;
    logic [ALU_W-1:0]       alu_b;
    logic [SUM_W-1:0]       sum_flat;
    logic [LANES*WIDTH-1:0] y_c;
    logic [LANES-1:0]       co_c;

    // Pack lanes into slots (zero-extended) and add each slot with its own carry chain.
    for (genvar k = 0; k < SEG; k++) begin : g_slot
        if (k < LANES) begin : g_lane
            assign alu_a[k*S +: S] = S'(a[k*WIDTH +: WIDTH]);
            assign alu_b[k*S +: S] = S'(b[k*WIDTH +: WIDTH]);
        end else begin : g_pad
            // Spare slot in three-lane mode: tied off, result ignored.
            assign alu_a[k*S +: S] = '0;
            assign alu_b[k*S +: S] = '0;
        end
        assign sum_flat[k*(S+1) +: (S+1)] =
            {1'b0, alu_a[k*S +: S]} + {1'b0, alu_b[k*S +: S]};
    end

    // Extract lane sums; bit WIDTH of the slot sum is the lane carry
    // (it is the slot carry-out when the lane fills the slot).
    for (genvar i = 0; i < LANES; i++) begin : g_out
        assign y_c[i*WIDTH +: WIDTH] = sum_flat[i*(S+1) +: WIDTH];
        assign co_c[i]               = sum_flat[i*(S+1) + WIDTH];
    end

    // Upper slot bits above the lane carry and the spare slot are discarded.
    logic unused_sum;
    assign unused_sum = ^sum_flat;

`ifdef DSP_SIMD_ADD_PREG_EN
    // P-register: capture sums on clock, clear asynchronously while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y  <= '0;
            co <= '0;
        end else begin
            y  <= y_c;
            co <= co_c;
        end
    end
`else
    // No P-register: outputs follow operands in the same cycle.
    assign y  = y_c;
    assign co = co_c;

    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
`endif

endmodule

// File: tb/tb_dsp_simd_add.sv
// Directed bench for dsp_simd_add in the four shipped lane/width configurations.
// Builds with or without DSP_SIMD_ADD_PREG_EN; expectations adapt to the latency.
`timescale 1ns/1ps
module tb_dsp_simd_add;

    logic clock = 1'b0;
    logic reset;

    logic [7:0]  a8,  b8,  y8;
    logic        co8;
    logic [31:0] a32, b32, y32;
    logic        co32;
    logic [47:0] a24, b24, y24;
    logic [1:0]  co24;
    logic [35:0] a12, b12, y12;
    logic [2:0]  co12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dsp_simd_add #(.LANES(1), .WIDTH(8)) u_l1w8 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .y(y8), .co(co8));
    dsp_simd_add #(.LANES(1), .WIDTH(32)) u_l1w32 (
        .clock(clock), .reset(reset), .a(a32), .b(b32), .y(y32), .co(co32));
    dsp_simd_add #(.LANES(2), .WIDTH(24)) u_l2w24 (
        .clock(clock), .reset(reset), .a(a24), .b(b24), .y(y24), .co(co24));
    dsp_simd_add #(.LANES(3), .WIDTH(12)) u_l3w12 (
        .clock(clock), .reset(reset), .a(a12), .b(b12), .y(y12), .co(co12));

    // Wait until a result driven at the preceding negedge is observable.
    task automatic settle();
`ifdef DSP_SIMD_ADD_PREG_EN
        @(posedge clock);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        a8 = 8'hFF; b8 = 8'h10;
        a12 = 36'h019_FE9_001; b12 = 36'h007_FF9_FF0;
        @(posedge clock);
        #1;
`ifdef DSP_SIMD_ADD_PREG_EN
        n_checks++;
        if ({co8, y8} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h000);
        end
        n_checks++;
        if ({co12, y12} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h0);
        end
        // Release reset; first rising edge afterwards yields the first result.
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
`endif
        n_checks++;
        if ({co8, y8} !== 9'h10F) begin
            n_fail++;
            $display("FAIL first_result_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h10F);
        end
        reset = 1'b1;
    endtask

    task automatic test_scalar();
        @(negedge clock);
        a8 = 8'h00; b8 = 8'h00;
        a32 = 32'h0000_0001; b32 = 32'hFFFF_0001;
        settle();
        n_checks++;
        if ({co8, y8} !== 9'h000) begin
            n_fail++;
            $display("FAIL zero_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h000);
        end
        n_checks++;
        if ({co32, y32} !== 33'h0_FFFF_0002) begin
            n_fail++;
            $display("FAIL add_l1w32: got co/y=%h expected %h", {co32, y32}, 33'h0_FFFF_0002);
        end
        @(negedge clock);
        a8 = 8'hFF; b8 = 8'h01;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001;
        settle();
        n_checks++;
        if ({co8, y8} !== 9'h100) begin
            n_fail++;
            $display("FAIL wrap_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h100);
        end
        n_checks++;
        if ({co32, y32} !== 33'h1_0000_0000) begin
            n_fail++;
            $display("FAIL wrap_l1w32: got co/y=%h expected %h", {co32, y32}, 33'h1_0000_0000);
        end
    endtask

    task automatic test_dual();
        @(negedge clock);
        a24 = 48'h000017_FFFFFF; b24 = 48'h000007_000010;
        settle();
        n_checks++;
        if ({co24, y24} !== 50'h1_00001E_00000F) begin
            n_fail++;
            $display("FAIL dual_l2w24: got co/y=%h expected %h", {co24, y24}, 50'h1_00001E_00000F);
        end
        // Lane-0 carry must not leak into an idle lane 1.
        @(negedge clock);
        a24 = 48'h000000_FFFFFF; b24 = 48'h000000_000001;
        settle();
        n_checks++;
        if ({co24, y24} !== 50'h1_000000_000000) begin
            n_fail++;
            $display("FAIL leak_l2w24: got co/y=%h expected %h", {co24, y24}, 50'h1_000000_000000);
        end
        @(negedge clock);
        a24 = 48'hFFFFFF_FFFFFF; b24 = 48'hFFFFFF_FFFFFF;
        settle();
        n_checks++;
        if ({co24, y24} !== 50'h3_FFFFFE_FFFFFE) begin
            n_fail++;
            $display("FAIL max_l2w24: got co/y=%h expected %h", {co24, y24}, 50'h3_FFFFFE_FFFFFE);
        end
    endtask

    task automatic test_triple();
        @(negedge clock);
        a12 = 36'h019_FE9_001; b12 = 36'h007_FF9_FF0;
        settle();
        n_checks++;
        if ({co12, y12} !== 39'h2_020_FE2_FF1) begin
            n_fail++;
            $display("FAIL triple_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h2_020_FE2_FF1);
        end
        @(negedge clock);
        a12 = 36'hFFF_FFF_FFF; b12 = 36'h001_001_001;
        settle();
        n_checks++;
        if ({co12, y12} !== 39'h7_000_000_000) begin
            n_fail++;
            $display("FAIL wrap_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h7_000_000_000);
        end
        @(negedge clock);
        a12 = 36'h0; b12 = 36'h0;
        settle();
        n_checks++;
        if ({co12, y12} !== 39'h0) begin
            n_fail++;
            $display("FAIL zero_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h0);
        end
        @(negedge clock);
        a12 = 36'hFFF_FFF_FFF; b12 = 36'hFFF_FFF_FFF;
        settle();
        n_checks++;
        if ({co12, y12} !== 39'h7_FFE_FFE_FFE) begin
            n_fail++;
            $display("FAIL max_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h7_FFE_FFE_FFE);
        end
        @(negedge clock);
        a12 = 36'h000_FFF_000; b12 = 36'h000_001_000;
        settle();
        n_checks++;
        if ({co12, y12} !== 39'h2_000_000_000) begin
            n_fail++;
            $display("FAIL leak_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h2_000_000_000);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [8:0] ve [4];
        va = '{8'h01, 8'h80, 8'h7F, 8'hAA};
        vb = '{8'h02, 8'h80, 8'h01, 8'h55};
        ve = '{9'h003, 9'h100, 9'h080, 9'h0FF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a8 = va[i]; b8 = vb[i];
            settle();
            n_checks++;
            if ({co8, y8} !== ve[i]) begin
                n_fail++;
                $display("FAIL b2b_l1w8[%0d]: got co/y=%h expected %h", i, {co8, y8}, ve[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock);
        a8 = 8'h01; b8 = 8'h02;
        settle();
        n_checks++;
        if ({co8, y8} !== 9'h003) begin
            n_fail++;
            $display("FAIL pre_drop_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h003);
        end
        // New operands in flight, then reset drops between clock edges.
        @(negedge clock);
        a8 = 8'h10; b8 = 8'h20;
        #1;
        reset = 1'b0;
        #1;
`ifdef DSP_SIMD_ADD_PREG_EN
        n_checks++;
        if ({co8, y8} !== 9'h000) begin
            n_fail++;
            $display("FAIL async_clear_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h000);
        end
        n_checks++;
        if ({co12, y12} !== 39'h0) begin
            n_fail++;
            $display("FAIL async_clear_l3w12: got co/y=%h expected %h", {co12, y12}, 39'h0);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if ({co8, y8} !== 9'h000) begin
            n_fail++;
            $display("FAIL hold_clear_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h000);
        end
        @(negedge clock);
        reset = 1'b1;
        settle();
`endif
        n_checks++;
        if ({co8, y8} !== 9'h030) begin
            n_fail++;
            $display("FAIL post_drop_l1w8: got co/y=%h expected %h", {co8, y8}, 9'h030);
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        a24 = '0; b24 = '0; a12 = '0; b12 = '0;
        test_reset();
        test_scalar();
        test_dual();
        test_triple();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
